// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: PC/IF-ID enables, bubble/flush strobes, ALU forwarding selects and perf counters.
// Optional HAZARD_FWD_EN: forwarding enabled and only load-use stalls; otherwise no forwarding and stall on any RAW.
module pipe_hazard_ctrl #(
    parameter int ASIZE        = 5,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [ASIZE-1:0] id_rs,
    input  logic [ASIZE-1:0] id_rt,
    input  logic             id_uses_rt,
    input  logic [ASIZE-1:0] ex_rs,
    input  logic [ASIZE-1:0] ex_rt,
    input  logic             ex_memread,
    input  logic             ex_wen,
    input  logic [ASIZE-1:0] ex_waddr,
    input  logic             mem_wen,
    input  logic [ASIZE-1:0] mem_waddr,
    input  logic             wb_wen,
    input  logic [ASIZE-1:0] wb_waddr,
    input  logic             branch_taken,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idexe_bubble,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             pc_sel,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);
    typedef enum logic {RUN, FLUSH} state_t;
    localparam logic [1:0] FL_LOAD  = 2'(FLUSH_CYCLES - 1);
    localparam state_t     BR_STATE = (FLUSH_CYCLES == 1) ? RUN : FLUSH;
    state_t           r_state, w_state_nxt;
    logic [1:0]       r_flcnt, w_flcnt_nxt;
    logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;
    logic             w_ex_hit, w_mem_hit, w_wb_hit, w_src_ex, w_load_use, w_stall, w_stall_run;
    // Register 0 is hardwired, so a write to it is never a real destination.
    assign w_ex_hit   = ex_wen && ex_waddr != '0;
    assign w_mem_hit  = mem_wen && mem_waddr != '0;
    assign w_wb_hit   = wb_wen && wb_waddr != '0;
    assign w_src_ex   = w_ex_hit && (id_rs == ex_waddr || (id_uses_rt && id_rt == ex_waddr));
    assign w_load_use = ex_memread && w_src_ex;
`ifdef HAZARD_FWD_EN
    assign w_stall = w_load_use;
    assign fwd_a   = (w_mem_hit && ex_rs == mem_waddr) ? 2'b01 : (w_wb_hit && ex_rs == wb_waddr) ? 2'b10 : 2'b00;
    assign fwd_b   = (w_mem_hit && ex_rt == mem_waddr) ? 2'b01 : (w_wb_hit && ex_rt == wb_waddr) ? 2'b10 : 2'b00;
`else
    logic w_src_mem, w_src_wb, w_unused;
    assign w_src_mem = w_mem_hit && (id_rs == mem_waddr || (id_uses_rt && id_rt == mem_waddr));
    assign w_src_wb  = w_wb_hit && (id_rs == wb_waddr || (id_uses_rt && id_rt == wb_waddr));
    assign w_stall   = w_src_ex || w_src_mem || w_src_wb;
    assign w_unused  = ^{ex_rs, ex_rt, w_load_use};
    assign fwd_a     = 2'b00;
    assign fwd_b     = 2'b00;
`endif
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= RUN;
            r_flcnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_flcnt <= w_flcnt_nxt;
        end
    end
    // A branch seen in FLUSH is re-serviced, so it reloads the counter from either state.
    always_comb begin
        w_state_nxt = branch_taken ? BR_STATE : (r_state == FLUSH && r_flcnt > 2'd1) ? FLUSH : RUN;
        w_flcnt_nxt = branch_taken ? FL_LOAD : (r_state == FLUSH && r_flcnt != 2'd0) ? r_flcnt - 2'd1 : r_flcnt;
    end
    // Holding rst low masks a live branch_taken so the pipeline sees clean RUN defaults.
    always_comb begin
        w_stall_run  = rst && r_state == RUN && !branch_taken && w_stall;
        pc_sel       = rst && branch_taken;
        pc_en        = !w_stall_run;
        ifid_en      = !w_stall_run;
        ifid_flush   = rst && (r_state == FLUSH || branch_taken);
        idexe_bubble = ifid_flush || w_stall_run;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (!pc_en && !(&r_stall_cnt)) r_stall_cnt <= r_stall_cnt + 1'b1;
            if (pc_sel && !(&r_flush_cnt)) r_flush_cnt <= r_flush_cnt + 1'b1;
        end
    end
    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
endmodule
